apb_protocol_checker: RTL
=========================

APB_PROTOCOL_CHECKER -- requirements
Module: apb_protocol_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 SHALL have parameter NSLAVES, default 4, PSEL vector width.
REQ-004 SHALL have parameter MAX_WAIT, default 16, wait-state timeout threshold (>=1).
REQ-005 SHALL have parameter CNT_WIDTH, default 16, statistic counter width.
REQ-006 SHALL have one clock, PCLK; reset is PRESETn, synchronous and active-low.
REQ-007 SHALL have ports (name direction width meaning):
 PCLK in 1 clock
 PRESETn in 1 synchronous active-low reset
 PSEL in NSLAVES one-hot slave selects
 PADDR in ADDR_WIDTH address
 PWRITE in 1 direction
 PSTRB in DATA_WIDTH/8 write strobes
 PWDATA in DATA_WIDTH write data
 PENABLE in 1 access-phase enable
 PREADY in 1 slave ready
 PSLVERR in 1 slave error
 clr_i in 1 clear statistics and flags
 err_valid out 1 error pulse
 err_code out 3 highest-priority error this cycle
 err_addr out ADDR_WIDTH PADDR sampled with error
 err_flags out 7 sticky error bits (bit n-1 = code n)
 err_cnt out CNT_WIDTH error-cycle count
 xfer_done out 1 transfer-complete pulse
 xfer_write out 1 direction of completed transfer
 xfer_slverr out 1 PSLVERR of completed transfer
 xfer_waits out CNT_WIDTH wait states of completed transfer
 xfer_cnt out CNT_WIDTH completed-transfer count

Function
REQ-008 SHALL be a passive monitor; all outputs registered, reported one PCLK after the sampled edge.
REQ-009 SHALL implement FSM IDLE/SETUP/ACCESS tracking bus phase.
REQ-010 IDLE: |PSEL && !PENABLE -> SETUP, capturing PADDR, PWRITE, PSTRB, PWDATA, PSEL; |PSEL && PENABLE -> code 2 NO_SETUP, stay IDLE.
REQ-011 SETUP: PENABLE=1 with PSEL equal to captured -> ACCESS, wait counter=0; otherwise code 3 NO_ENABLE, re-evaluate inputs as IDLE same cycle.
REQ-012 ACCESS: any change vs captured of PADDR, PWRITE, PSTRB, PSEL, or PWDATA when write -> code 4 UNSTABLE; PENABLE or PSEL dropped before PREADY -> code 3, go IDLE.
REQ-013 ACCESS with PREADY=1: pulse xfer_done, output xfer_write, xfer_slverr=PSLVERR, xfer_waits=wait count, increment xfer_cnt (saturating), go IDLE.
REQ-014 ACCESS with PREADY=0: increment wait count (saturating); when count reaches MAX_WAIT raise code 5 TIMEOUT once per transfer, keep monitoring.
REQ-015 Entering SETUP with PWRITE=0 and PSTRB!=0 -> code 6 STRB_READ.
REQ-016 Any state: more than one PSEL bit set -> code 1 MULTI_SEL; PENABLE=1 with PSEL=0 -> code 7 EN_NOSEL.
REQ-017 Simultaneous errors: err_code = lowest code number; err_flags ORs all detected bits; err_cnt increments by 1 per error cycle, saturating at all-ones.
REQ-018 PSLVERR SHALL be ignored unless ACCESS && PREADY.
REQ-019 clr_i zeroes err_flags, err_cnt, xfer_cnt, then the same cycle's events apply (error with clr_i -> err_cnt=1); FSM unaffected.
REQ-020 Back-to-back: SETUP sampled the cycle after completion SHALL be accepted without error.

Reset
REQ-021 PRESETn=0 at PCLK edge: FSM IDLE, all outputs and captured registers zero; mid-transfer reset abandons transfer with no xfer_done or error.
REQ-022 First cycle after reset release SHALL be evaluated as IDLE.

Verification
REQ-023 Write PSEL=4'b0010, PADDR=0x40, 2 wait states, PREADY -> xfer_done=1, xfer_write=1, xfer_waits=2, xfer_cnt=1, no error.
REQ-024 PADDR changes 0x40->0x44 during ACCESS -> err_valid, err_code=4, err_addr=0x44, err_flags[3]=1.
REQ-025 PREADY low 16 cycles (MAX_WAIT=16) -> single code 5 at 16th wait; later PREADY completes with xfer_waits=16+.
REQ-026 PSEL=4'b0011 with PENABLE=1 from IDLE -> err_code=1, err_flags=7'b0000011, err_cnt=1.
REQ-027 Read with PSTRB=0xF, then clr_i -> err_code=6; after clr_i flags and counts 0.
REQ-028 PRESETn low during ACCESS -> outputs zero next cycle, subsequent clean transfer counted as xfer_cnt=1.

Source files
------------

// File: rtl/apb_protocol_checker.sv
// Passive APB bus monitor: tracks IDLE/SETUP/ACCESS, flags protocol
// violations and reports completed-transfer statistics.
module apb_protocol_checker #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NSLAVES    = 4,
   parameter int unsigned MAX_WAIT   = 16,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic [NSLAVES-1:0]      PSEL,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic                    PWRITE,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic                    PENABLE,
   input  logic                    PREADY,
   input  logic                    PSLVERR,
   input  logic                    clr_i,
   output logic                    err_valid,
   output logic [2:0]              err_code,
   output logic [ADDR_WIDTH-1:0]   err_addr,
   output logic [6:0]              err_flags,
   output logic [CNT_WIDTH-1:0]    err_cnt,
   output logic                    xfer_done,
   output logic                    xfer_write,
   output logic                    xfer_slverr,
   output logic [CNT_WIDTH-1:0]    xfer_waits,
   output logic [CNT_WIDTH-1:0]    xfer_cnt
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cap_addr_q, cap_addr_d;
   logic                    cap_write_q, cap_write_d;
   logic [STRB_WIDTH-1:0]   cap_strb_q, cap_strb_d;
   logic [DATA_WIDTH-1:0]   cap_wdata_q, cap_wdata_d;
   logic [NSLAVES-1:0]      cap_sel_q, cap_sel_d;
   logic [CNT_WIDTH-1:0]    wait_q, wait_d;
   logic                    to_done_q, to_done_d;
   logic                    err_valid_q, err_valid_d;
   logic [2:0]              err_code_q, err_code_d;
   logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
   logic [6:0]              err_flags_q, err_flags_d;
   logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
   logic                    xfer_done_q, xfer_done_d;
   logic                    xfer_write_q, xfer_write_d;
   logic                    xfer_slverr_q, xfer_slverr_d;
   logic [CNT_WIDTH-1:0]    xfer_waits_q, xfer_waits_d;
   logic [CNT_WIDTH-1:0]    xfer_cnt_q, xfer_cnt_d;

   // Scratch values for the next-state process
   logic [6:0]              evt;
   logic                    any_sel, idle_eval, access_eval, unstable, to_base;
   logic [CNT_WIDTH-1:0]    wait_base, err_base, xfer_base;

   // Next-state, protocol checks and statistics
   always_comb begin
      state_d       = state_q;
      cap_addr_d    = cap_addr_q;
      cap_write_d   = cap_write_q;
      cap_strb_d    = cap_strb_q;
      cap_wdata_d   = cap_wdata_q;
      cap_sel_d     = cap_sel_q;
      wait_d        = wait_q;
      to_done_d     = to_done_q;
      err_valid_d   = 1'b0;
      err_code_d    = 3'd0;
      err_addr_d    = err_addr_q;
      err_flags_d   = err_flags_q;
      err_cnt_d     = err_cnt_q;
      xfer_done_d   = 1'b0;
      xfer_write_d  = xfer_write_q;
      xfer_slverr_d = xfer_slverr_q;
      xfer_waits_d  = xfer_waits_q;
      xfer_cnt_d    = xfer_cnt_q;
      evt           = 7'd0;
      idle_eval     = 1'b0;
      access_eval   = 1'b0;
      unstable      = 1'b0;
      wait_base     = wait_q;
      to_base       = to_done_q;
      err_base      = '0;
      xfer_base     = '0;

      any_sel = |PSEL;
      if ((PSEL & (PSEL - NSLAVES'(1))) != '0) evt[0] = 1'b1;
      if (PENABLE && !any_sel)                 evt[6] = 1'b1;

      case (state_q)
         S_IDLE:   idle_eval = 1'b1;
         // The first enable cycle is itself an access cycle, so a
         // zero-wait transfer completes here with a fresh wait count.
         S_SETUP: begin
            if (PENABLE && (PSEL == cap_sel_q)) begin
               access_eval = 1'b1;
               wait_base   = '0;
               to_base     = 1'b0;
            end else begin
               evt[2]    = 1'b1;
               idle_eval = 1'b1;
            end
         end
         S_ACCESS: access_eval = 1'b1;
         default:  state_d = S_IDLE;
      endcase

      if (idle_eval) begin
         state_d = S_IDLE;
         if (any_sel && !PENABLE) begin
            state_d     = S_SETUP;
            cap_addr_d  = PADDR;
            cap_write_d = PWRITE;
            cap_strb_d  = PSTRB;
            cap_wdata_d = PWDATA;
            cap_sel_d   = PSEL;
            if (!PWRITE && (PSTRB != '0)) evt[5] = 1'b1;
         end else if (any_sel && PENABLE) begin
            evt[1] = 1'b1;
         end
      end

      if (access_eval) begin
         unstable = (PADDR != cap_addr_q) || (PWRITE != cap_write_q) ||
                    (PSTRB != cap_strb_q) || (PSEL != cap_sel_q) ||
                    (cap_write_q && (PWDATA != cap_wdata_q));
         if (unstable) evt[3] = 1'b1;
         if (!PENABLE || !any_sel) begin
            evt[2]  = 1'b1;
            state_d = S_IDLE;
         end else if (PREADY) begin
            state_d       = S_IDLE;
            xfer_done_d   = 1'b1;
            xfer_write_d  = cap_write_q;
            xfer_slverr_d = PSLVERR;
            xfer_waits_d  = wait_base;
         end else begin
            state_d   = S_ACCESS;
            wait_d    = (wait_base == '1) ? wait_base : wait_base + CNT_WIDTH'(1);
            to_done_d = to_base;
            if (!to_base && (wait_d >= CNT_WIDTH'(MAX_WAIT))) begin
               evt[4]    = 1'b1;
               to_done_d = 1'b1;
            end
         end
      end

      // Clear applies first, then this cycle's events accumulate
      err_flags_d = (clr_i ? 7'd0 : err_flags_q) | evt;
      err_base    = clr_i ? '0 : err_cnt_q;
      xfer_base   = clr_i ? '0 : xfer_cnt_q;
      err_cnt_d   = err_base;
      xfer_cnt_d  = xfer_base;
      if (evt != 7'd0) begin
         err_valid_d = 1'b1;
         err_addr_d  = PADDR;
         err_cnt_d   = (err_base == '1) ? err_base : err_base + CNT_WIDTH'(1);
         for (int i = 6; i >= 0; i--) begin
            if (evt[i]) err_code_d = 3'(i + 1);
         end
      end
      if (xfer_done_d) begin
         xfer_cnt_d = (xfer_base == '1) ? xfer_base : xfer_base + CNT_WIDTH'(1);
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q       <= S_IDLE;
         cap_addr_q    <= '0;
         cap_write_q   <= 1'b0;
         cap_strb_q    <= '0;
         cap_wdata_q   <= '0;
         cap_sel_q     <= '0;
         wait_q        <= '0;
         to_done_q     <= 1'b0;
         err_valid_q   <= 1'b0;
         err_code_q    <= 3'd0;
         err_addr_q    <= '0;
         err_flags_q   <= 7'd0;
         err_cnt_q     <= '0;
         xfer_done_q   <= 1'b0;
         xfer_write_q  <= 1'b0;
         xfer_slverr_q <= 1'b0;
         xfer_waits_q  <= '0;
         xfer_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         cap_addr_q    <= cap_addr_d;
         cap_write_q   <= cap_write_d;
         cap_strb_q    <= cap_strb_d;
         cap_wdata_q   <= cap_wdata_d;
         cap_sel_q     <= cap_sel_d;
         wait_q        <= wait_d;
         to_done_q     <= to_done_d;
         err_valid_q   <= err_valid_d;
         err_code_q    <= err_code_d;
         err_addr_q    <= err_addr_d;
         err_flags_q   <= err_flags_d;
         err_cnt_q     <= err_cnt_d;
         xfer_done_q   <= xfer_done_d;
         xfer_write_q  <= xfer_write_d;
         xfer_slverr_q <= xfer_slverr_d;
         xfer_waits_q  <= xfer_waits_d;
         xfer_cnt_q    <= xfer_cnt_d;
      end
   end

   assign err_valid   = err_valid_q;
   assign err_code    = err_code_q;
   assign err_addr    = err_addr_q;
   assign err_flags   = err_flags_q;
   assign err_cnt     = err_cnt_q;
   assign xfer_done   = xfer_done_q;
   assign xfer_write  = xfer_write_q;
   assign xfer_slverr = xfer_slverr_q;
   assign xfer_waits  = xfer_waits_q;
   assign xfer_cnt    = xfer_cnt_q;

endmodule
